// File: rtl/result_pkg.sv
// Shared result-path constants and FSM encoding for result_drain and the MemoryB sizing.
package result_pkg;

  localparam int unsigned RESULT_DATA_W = 8;
  localparam int unsigned RESULT_DEPTH  = 4;
  localparam int unsigned RESULT_ADDR_W = 2;

  typedef logic [0:0] state_t;

  localparam state_t FILL  = 1'b0;
  localparam state_t DRAIN = 1'b1;

endpackage

// File: rtl/result_buf_regs.sv
// DEPTH x DATA_W register array: one synchronous write port, one combinational read port.
module result_buf_regs
  import result_pkg::*;
#(
  parameter int unsigned DATA_W = RESULT_DATA_W,
  parameter int unsigned DEPTH  = RESULT_DEPTH,
  parameter int unsigned ADDR_W = RESULT_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are intentionally not reset; the FSM never exposes an unwritten entry.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/result_drain.sv
// Batch buffer between the result write stream and a stallable valid/ready consumer.
// Optional RESULT_DRAIN_CHECKSUM_EN appends a mod-2^DATA_W checksum beat to each batch.
module result_drain
  import result_pkg::*;
#(
  parameter int unsigned DATA_W = RESULT_DATA_W,
  parameter int unsigned DEPTH  = RESULT_DEPTH,
  parameter int unsigned ADDR_W = RESULT_ADDR_W
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              overflow
);

`ifdef RESULT_DRAIN_CHECKSUM_EN
  localparam int unsigned RD_W = ADDR_W + 1;
`else
  localparam int unsigned RD_W = ADDR_W;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [RD_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic              ovf_q, ovf_d;
  logic              buf_we;
  logic [DATA_W-1:0] buf_rdata;
  logic              last_beat_c;
`ifdef RESULT_DRAIN_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
`endif

  result_buf_regs #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (buf_rdata)
  );

`ifdef RESULT_DRAIN_CHECKSUM_EN
  assign last_beat_c = (rd_ptr_q == RD_W'(DEPTH));
`else
  assign last_beat_c = (rd_ptr_q == RD_W'(DEPTH - 1));
`endif

  // Next-state, pointer and sticky-flag logic; flush outranks writes and handshakes.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    buf_we   = 1'b0;
`ifdef RESULT_DRAIN_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    if (flush) begin
      state_d  = FILL;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
`ifdef RESULT_DRAIN_CHECKSUM_EN
      csum_d   = '0;
`endif
    end else begin
      case (state_q)
        FILL: begin
          if (wr_en) begin
            buf_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
`ifdef RESULT_DRAIN_CHECKSUM_EN
            csum_d   = csum_q + wr_data;
`endif
            if (wr_ptr_q == ADDR_W'(DEPTH - 1)) state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (wr_en) ovf_d = 1'b1;
          if (out_ready) begin
            if (last_beat_c) begin
              state_d  = FILL;
              wr_ptr_d = '0;
              rd_ptr_d = '0;
`ifdef RESULT_DRAIN_CHECKSUM_EN
              csum_d   = '0;
`endif
            end else begin
              rd_ptr_d = rd_ptr_q + RD_W'(1);
            end
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_q  <= FILL;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
`ifdef RESULT_DRAIN_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
`ifdef RESULT_DRAIN_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  // Outputs decode registered state and storage only, so they hold steady during a stall.
  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q == DRAIN);
  assign overflow  = ovf_q;
  assign out_last  = (state_q == DRAIN) && last_beat_c;
`ifdef RESULT_DRAIN_CHECKSUM_EN
  assign out_data  = (state_q != DRAIN) ? '0 : (last_beat_c ? csum_q : buf_rdata);
`else
  assign out_data  = (state_q != DRAIN) ? '0 : buf_rdata;
`endif

endmodule
